// File: rtl/regfile_2w2r_sb.sv
// Two-write / two-read register file with a per-register pending scoreboard.
// Reads, busy flags and the pending count are registered and see the same edge's updates.
module regfile_2w2r_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wr_en_a,
  input  logic [ADDR_W-1:0] wr_addr_a,
  input  logic [DATA_W-1:0] wr_data_a,
  input  logic              wr_en_b,
  input  logic [ADDR_W-1:0] wr_addr_b,
  input  logic [DATA_W-1:0] wr_data_b,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [ADDR_W:0]   busy_count
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]   mem_q [NUM_REGS];
  logic [DATA_W-1:0]   mem_d [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_d;
  logic [DATA_W-1:0]   rd_data1_q, rd_data2_q;
  logic                rd_busy1_q, rd_busy2_q;
  logic [ADDR_W:0]     busy_count_q;
  logic                we_a_s, we_b_s, rsv_s;

  function automatic logic [ADDR_W:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [ADDR_W:0] c;
    c = {(ADDR_W+1){1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      c = c + {{ADDR_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Next array and pending state; B overrides A, a reserve overrides a clearing write.
  always_comb begin
    we_a_s = wr_en_a && !((ZERO_REG != 0) && (wr_addr_a == {ADDR_W{1'b0}}));
    we_b_s = wr_en_b && !((ZERO_REG != 0) && (wr_addr_b == {ADDR_W{1'b0}}));
    rsv_s  = rsv_en  && !((ZERO_REG != 0) && (rsv_addr  == {ADDR_W{1'b0}}));
    pend_d = pend_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      mem_d[i] = (we_b_s && (wr_addr_b == ADDR_W'(i))) ? wr_data_b :
                 (we_a_s && (wr_addr_a == ADDR_W'(i))) ? wr_data_a : mem_q[i];
      pend_d[i] = (rsv_s && (rsv_addr == ADDR_W'(i))) ? 1'b1 :
                  ((we_a_s && (wr_addr_a == ADDR_W'(i))) ||
                   (we_b_s && (wr_addr_b == ADDR_W'(i)))) ? 1'b0 : pend_q[i];
    end
  end

  // Storage, scoreboard and registered read-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
      pend_q       <= {NUM_REGS{1'b0}};
      rd_data1_q   <= {DATA_W{1'b0}};
      rd_data2_q   <= {DATA_W{1'b0}};
      rd_busy1_q   <= 1'b0;
      rd_busy2_q   <= 1'b0;
      busy_count_q <= {(ADDR_W+1){1'b0}};
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= mem_d[i];
      end
      pend_q       <= pend_d;
      rd_data1_q   <= mem_d[rd_addr1];
      rd_data2_q   <= mem_d[rd_addr2];
      rd_busy1_q   <= pend_d[rd_addr1];
      rd_busy2_q   <= pend_d[rd_addr2];
      busy_count_q <= popcount(pend_d);
    end
  end

  assign rd_data1   = rd_data1_q;
  assign rd_data2   = rd_data2_q;
  assign rd_busy1   = rd_busy1_q;
  assign rd_busy2   = rd_busy2_q;
  assign busy_count = busy_count_q;

endmodule

// File: tb/tb_regfile_2w2r_sb.sv
// Randomized and directed bench for regfile_2w2r_sb against an array-based reference model.
module tb_regfile_2w2r_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rd_addr1 = 5'd0, rd_addr2 = 5'd0;
  logic [31:0] rd_data1, rd_data2;
  logic        rd_busy1, rd_busy2;
  logic        wr_en_a = 1'b0, wr_en_b = 1'b0, rsv_en = 1'b0;
  logic [4:0]  wr_addr_a = 5'd0, wr_addr_b = 5'd0, rsv_addr = 5'd0;
  logic [31:0] wr_data_a = 32'd0, wr_data_b = 32'd0;
  logic [5:0]  busy_count;

  regfile_2w2r_sb dut (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
    .wr_en_a(wr_en_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
    .wr_en_b(wr_en_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // reference model state and expected outputs
  logic [31:0] m_mem [32];
  bit          m_pend [32];
  logic [31:0] exp_d1, exp_d2;
  logic        exp_b1, exp_b2;
  int          exp_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = 32'd0;
      m_pend[i] = 1'b0;
    end
  endtask

  task automatic model_expect();
    exp_d1 = m_mem[rd_addr1];
    exp_d2 = m_mem[rd_addr2];
    exp_b1 = m_pend[rd_addr1];
    exp_b2 = m_pend[rd_addr2];
    exp_cnt = 0;
    for (int i = 0; i < 32; i++) exp_cnt += int'(m_pend[i]);
  endtask

  // One clock edge as the specification describes it: writes A then B, clears, then reserve.
  task automatic model_step();
    if (wr_en_a && wr_addr_a != 5'd0) begin
      m_mem[wr_addr_a] = wr_data_a;
      m_pend[wr_addr_a] = 1'b0;
    end
    if (wr_en_b && wr_addr_b != 5'd0) begin
      m_mem[wr_addr_b] = wr_data_b;
      m_pend[wr_addr_b] = 1'b0;
    end
    if (rsv_en && rsv_addr != 5'd0) m_pend[rsv_addr] = 1'b1;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) model_clear();
    else model_step();
    model_expect();
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en_a = 1'b0;
    wr_en_b = 1'b0;
    rsv_en  = 1'b0;
  endtask

  // compare DUT outputs against the model every cycle once out of reset
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rd_data1", {32'd0, rd_data1}, {32'd0, exp_d1});
      chk("rd_data2", {32'd0, rd_data2}, {32'd0, exp_d2});
      chk("rd_busy1", {63'd0, rd_busy1}, {63'd0, exp_b1});
      chk("rd_busy2", {63'd0, rd_busy2}, {63'd0, exp_b2});
      chk("busy_count", {58'd0, busy_count}, 64'(exp_cnt));
    end
  end

  initial begin
    model_clear();
    model_expect();
    #1;
    chk("reset_data1", {32'd0, rd_data1}, 64'd0);
    chk("reset_count", {58'd0, busy_count}, 64'd0);
    cyc();
    cyc();
    rst = 1'b0;
    chk_en = 1'b1;

    // write then read with bypass
    wr_en_a = 1'b1; wr_addr_a = 5'd3; wr_data_a = 32'h0000_00AA; rd_addr1 = 5'd3;
    cyc(); idle();
    chk("wr_bypass", {32'd0, rd_data1}, 64'h0000_00AA);

    // port collision, B wins
    wr_en_a = 1'b1; wr_addr_a = 5'd7; wr_data_a = 32'h11;
    wr_en_b = 1'b1; wr_addr_b = 5'd7; wr_data_b = 32'h22; rd_addr1 = 5'd7;
    cyc(); idle();
    chk("collision", {32'd0, rd_data1}, 64'h22);

    // zero register
    wr_en_a = 1'b1; wr_addr_a = 5'd0; wr_data_a = 32'hFFFF_FFFF;
    rsv_en = 1'b1; rsv_addr = 5'd0; rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    cyc(); idle();
    chk("zero_data", {32'd0, rd_data1}, 64'd0);
    chk("zero_busy", {63'd0, rd_busy2}, 64'd0);
    chk("zero_count", {58'd0, busy_count}, 64'd0);

    // scoreboard
    rsv_en = 1'b1; rsv_addr = 5'd5; rd_addr1 = 5'd5; rd_addr2 = 5'd6;
    cyc();
    chk("rsv5_count", {58'd0, busy_count}, 64'd1);
    rsv_addr = 5'd6;
    cyc(); idle();
    chk("rsv6_count", {58'd0, busy_count}, 64'd2);
    wr_en_b = 1'b1; wr_addr_b = 5'd5; wr_data_b = 32'h55;
    cyc(); idle();
    chk("wr5_count", {58'd0, busy_count}, 64'd1);
    chk("wr5_busy", {63'd0, rd_busy1}, 64'd0);
    rsv_en = 1'b1; rsv_addr = 5'd6; wr_en_a = 1'b1; wr_addr_a = 5'd6; wr_data_a = 32'h66;
    cyc(); idle();
    chk("rsv_wins_busy", {63'd0, rd_busy2}, 64'd1);
    chk("rsv_wins_count", {58'd0, busy_count}, 64'd1);

    // fill all non-zero registers, then re-reserve
    for (int a = 1; a < 32; a++) begin
      rsv_en = 1'b1; rsv_addr = 5'(a);
      cyc();
    end
    chk("fill_count", {58'd0, busy_count}, 64'd31);
    rsv_addr = 5'd9;
    cyc(); idle();
    chk("rersv_count", {58'd0, busy_count}, 64'd31);

    // async reset mid-cycle
    rd_addr1 = 5'd3; rd_addr2 = 5'd7;
    cyc();
    chk("pre_rst_data", {32'd0, rd_data1}, 64'h0000_00AA);
    #2;
    rst = 1'b1;
    model_clear();
    model_expect();
    #1;
    chk("arst_data1", {32'd0, rd_data1}, 64'd0);
    chk("arst_data2", {32'd0, rd_data2}, 64'd0);
    chk("arst_busy1", {63'd0, rd_busy1}, 64'd0);
    chk("arst_count", {58'd0, busy_count}, 64'd0);
    cyc();
    rst = 1'b0;
    wr_en_a = 1'b1; wr_addr_a = 5'd4; wr_data_a = 32'h44; rd_addr2 = 5'd4;
    cyc(); idle();
    chk("post_rst_old", {32'd0, rd_data1}, 64'd0);
    chk("post_rst_new", {32'd0, rd_data2}, 64'h44);

    // randomized traffic, addresses biased to a small window for collisions
    for (int n = 0; n < 600; n++) begin
      wr_en_a   = ($urandom_range(0, 1) == 1);
      wr_en_b   = ($urandom_range(0, 2) == 0);
      rsv_en    = ($urandom_range(0, 1) == 1);
      wr_addr_a = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wr_addr_b = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      rsv_addr  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      rd_addr1  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      rd_addr2  = 5'($urandom);
      wr_data_a = $urandom;
      wr_data_b = $urandom;
      rst       = ($urandom_range(0, 99) == 0);
      cyc();
    end
    rst = 1'b0;
    idle();
    cyc();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_2w2r_sb.md
REGFILE_2W2R_SB -- requirements
Module: regfile_2w2r_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; NUM_REGS = 2**ADDR_W.
REQ-003 SHALL have parameter ZERO_REG, default 1, where 1 hardwires register 0 to zero.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port rd_addr1  in  ADDR_W  read port 1 address.
REQ-007 SHALL have port rd_addr2  in  ADDR_W  read port 2 address.
REQ-008 SHALL have port rd_data1  out  DATA_W  registered read port 1 data.
REQ-009 SHALL have port rd_data2  out  DATA_W  registered read port 2 data.
REQ-010 SHALL have port rd_busy1  out  1  registered pending flag of rd_addr1.
REQ-011 SHALL have port rd_busy2  out  1  registered pending flag of rd_addr2.
REQ-012 SHALL have port wr_en_a  in  1  write port A enable.
REQ-013 SHALL have port wr_addr_a  in  ADDR_W  write port A address.
REQ-014 SHALL have port wr_data_a  in  DATA_W  write port A data.
REQ-015 SHALL have ports wr_en_b, wr_addr_b, wr_data_b  in  1/ADDR_W/DATA_W  write port B, same meaning as port A.
REQ-016 SHALL have port rsv_en  in  1  reserve request; marks a register pending.
REQ-017 SHALL have port rsv_addr  in  ADDR_W  register to reserve.
REQ-018 SHALL have port busy_count  out  ADDR_W+1  registered number of pending registers.

Function
REQ-019 SHALL update the storage array on each rising edge from enabled write ports.
REQ-020 SHALL write only port B when both ports are enabled to the same address.
REQ-021 SHALL, when ZERO_REG=1, drop writes and reserves to address 0, and SHALL return 0 and busy 0 for it.
REQ-022 SHALL register reads with one-cycle latency: rd_dataN after edge k equals the array content after edge k's writes (write-before-read bypass).
REQ-023 SHALL keep one pending bit per register: rsv_en sets it, and a write on either port clears it.
REQ-024 SHALL keep the bit set when a reserve and a write hit the same address in the same cycle (reserve wins).
REQ-025 SHALL make rd_busyN after edge k equal the pending bit of rd_addrN after edge k's update (same bypass as data).
REQ-026 SHALL make busy_count after edge k equal the popcount of pending bits after edge k's update, in range 0..NUM_REGS.
REQ-027 SHALL ignore reserves to an already pending register, with no count change.
REQ-028 SHALL leave the array and outputs unchanged when no port is enabled, except rd_* tracking changed read addresses.
REQ-029 SHALL have no combinational path from any input to any output.

Reset
REQ-030 SHALL, while rst=1, force all registers, all pending bits, rd_data1/2, rd_busy1/2 and busy_count to 0 immediately without a clock edge.
REQ-031 SHALL take effect mid-operation: writes or reserves presented in the cycle rst deasserts are ignored only if rst is high at that edge.
REQ-032 SHALL resume normal operation on the first rising edge with rst=0.

Verification
REQ-033 SHALL cover write-then-read: wr_en_a, addr 3, data 0x0000_00AA, rd_addr1=3 in the same cycle -> rd_data1=0x0000_00AA after that edge.
REQ-034 SHALL cover a port collision: A and B both write addr 7, with A=0x11 and B=0x22 -> reading addr 7 returns 0x22.
REQ-035 SHALL cover the zero register: write 0xFFFF_FFFF to addr 0 and reserve addr 0 -> rd_data=0, rd_busy=0, busy_count=0.
REQ-036 SHALL cover the scoreboard:
- reserve 5, then 6 -> busy_count 1, then 2;
- port B writes 5 -> busy_count=1 and rd_busy for addr 5 = 0;
- same-cycle reserve and write of 6 -> stays pending, count 1.
REQ-037 SHALL cover fill: reserve all 31 non-zero addresses -> busy_count=31; re-reserving addr 9 -> still 31.
REQ-038 SHALL cover async reset: fill several registers, pulse rst between clock edges -> all outputs read 0 before the next edge, and reads of prior addresses return 0.
